// File: rtl/fetch_unit_pkg.sv
// Shared widths, constants and the instruction-buffer entry layout for the fetch unit.
package fetch_unit_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned INST_W = 32;

  localparam logic [XLEN-1:0] PC_INC           = XLEN'(4);
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; low bits of a target are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small circular FIFO with flush and occupancy count; head is read straight from registers.
module fetch_buffer #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [WIDTH-1:0]             head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited requests to the I-cache, in-order response buffering,
// and redirect handling that drops responses still in flight from the old path.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned     BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              imem_req_valid,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_inst,
  output logic              if_valid,
  output logic [XLEN-1:0]   if_pc,
  output logic [INST_W-1:0] if_inst,
  input  logic              id_ready
);

  localparam int unsigned CNT_W  = $clog2(BUF_DEPTH + 1);
  localparam int unsigned CRED_W = CNT_W + 1;

  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   pc_next;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  inflight_next;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  drop_cnt_next;
  logic [CNT_W-1:0]  buf_count;
  logic [CRED_W-1:0] credit_used;
  logic [XLEN-1:0]   aq_head;
  logic              req_fire;
  logic              resp_accept;
  logic              resp_keep;
  logic              pop;
  fetch_entry_t      ib_push;
  fetch_entry_t      ib_head;

  assign if_valid = !rst && (buf_count != '0);
  assign if_pc    = ib_head.pc;
  assign if_inst  = ib_head.inst;
  assign pop      = if_valid && id_ready && !redirect_valid;

  // A head consumed this cycle frees its slot, which keeps fetch at one per cycle.
  assign credit_used    = CRED_W'(inflight) + CRED_W'(buf_count) - CRED_W'(pop);
  assign imem_req_valid = !rst && !redirect_valid && (credit_used < CRED_W'(BUF_DEPTH));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign resp_accept   = !rst && imem_resp_valid && (inflight != '0);
  assign resp_keep     = resp_accept && !redirect_valid && (drop_cnt == '0);
  assign inflight_next = inflight + CNT_W'(req_fire) - CNT_W'(resp_accept);
  assign ib_push       = '{pc: aq_head, inst: imem_resp_inst};

  always_comb begin
    pc_next       = pc;
    drop_cnt_next = drop_cnt;
    if (redirect_valid) begin
      pc_next       = align_pc(redirect_pc);
      drop_cnt_next = inflight_next;
    end else begin
      if (req_fire) pc_next = pc + PC_INC;
      if (resp_accept && (drop_cnt != '0)) drop_cnt_next = drop_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      drop_cnt <= '0;
    end else begin
      pc       <= pc_next;
      drop_cnt <= drop_cnt_next;
    end
  end

  // Address queue: PC of every outstanding request; its occupancy is the inflight count.
  fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (XLEN)
  ) u_addr_q (
    .clk       (clk),
    .rst       (rst),
    .push      (req_fire),
    .push_data (pc),
    .pop       (resp_accept),
    .flush     (1'b0),
    .head_data (aq_head),
    .count     (inflight)
  );

  fetch_buffer #(
    .DEPTH ($clog2(1) + BUF_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_inst_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (resp_keep),
    .push_data (ib_push),
    .pop       (pop),
    .flush     (redirect_valid),
    .head_data (ib_head),
    .count     (buf_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural I-cache with variable latency, scoreboard of expected
// deliveries, a cycle-exact vector table and directed redirect/wrap/reset sequences.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
  localparam int          DEPTH       = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_inst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_ready;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC  (TB_RESET_PC),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_inst  (imem_resp_inst),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_inst         (if_inst),
    .id_ready        (id_ready)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    int          due;
    bit          stale;
  } cache_ent_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } sb_ent_t;

  typedef struct {
    logic        rst;
    logic        idr;
    logic        rdy;
    logic        erv;
    logic [31:0] eaddr;
    logic        eiv;
    logic [31:0] epc;
  } vec_t;

  cache_ent_t  cq[$];
  sb_ent_t     sb[$];
  int          cyc, lat, last_due;
  int          n_vec, n_err;
  bit          force_junk, resp_now, resp_stale, pop_now;
  bit          popped, hs_seen;
  logic [31:0] resp_pc, dut_pop_pc, hs_addr, model_pc;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cache presents the oldest due response, then outputs settle.
  task automatic drive_and_settle();
    cache_ent_t e;
    resp_now   = 1'b0;
    resp_stale = 1'b0;
    if (force_junk) begin
      imem_resp_valid = 1'b1;
      imem_resp_inst  = 32'hDEAD_BEEF;
    end else if (cq.size() != 0 && cq[0].due <= cyc) begin
      e = cq.pop_front();
      imem_resp_valid = 1'b1;
      imem_resp_inst  = e.inst;
      resp_now        = 1'b1;
      resp_stale      = e.stale;
      resp_pc         = e.addr;
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_inst  = $urandom;
    end
    #1;
  endtask

  task automatic finish_cycle();
    int used;
    int due;
    bit exp_rv;
    pop_now = (sb.size() != 0) && id_ready && !redirect_valid && !rst;
    used    = cq.size() + int'(resp_now) + sb.size() - int'(pop_now);
    exp_rv  = !rst && !redirect_valid && (used < DEPTH);
    check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    check("if_valid", 32'(if_valid), 32'((sb.size() != 0) && !rst));
    if (pop_now) begin
      check("if_pc", if_pc, sb[0].pc);
      check("if_inst", if_inst, sb[0].inst);
      popped     = 1'b1;
      dut_pop_pc = if_pc;
      void'(sb.pop_front());
    end
    if (imem_req_valid && imem_req_ready) begin
      check("req_addr", imem_req_addr, model_pc);
      hs_seen  = 1'b1;
      hs_addr  = imem_req_addr;
      due      = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      last_due = due;
      cq.push_back('{addr: model_pc, inst: inst_of(model_pc), due: due, stale: 1'b0});
      model_pc = model_pc + 32'd4;
    end
    if (resp_now && !resp_stale && !redirect_valid && !rst)
      sb.push_back('{pc: resp_pc, inst: imem_resp_inst});
    if (redirect_valid) begin
      sb.delete();
      foreach (cq[i]) cq[i].stale = 1'b1;
      model_pc = {redirect_pc[31:2], 2'b00};
    end
    if (rst) begin
      sb.delete();
      cq.delete();
      model_pc = TB_RESET_PC;
      last_due = cyc;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic tick();
    drive_and_settle();
    finish_cycle();
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic expect_first_pop(input string name, input logic [31:0] exp);
    popped = 1'b0;
    for (int k = 0; k < 30 && !popped; k++) tick();
    if (!popped) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: no instruction delivered within 30 cycles, expected pc %h", name, exp);
    end else begin
      check(name, dut_pop_pc, exp);
    end
  endtask

  task automatic expect_next_req(input string name, input logic [31:0] exp);
    hs_seen = 1'b0;
    for (int k = 0; k < 30 && !hs_seen; k++) tick();
    if (!hs_seen) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: no request accepted within 30 cycles, expected addr %h", name, exp);
    end else begin
      check(name, hs_addr, exp);
    end
  endtask

  vec_t tbl[20];

  initial begin
    // rst idr rdy | req_valid req_addr | if_valid if_pc
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h0C};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h0C};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h0C};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h0C};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h0C};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h18, 1'b1, 32'h10};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h14};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h20, 1'b1, 32'h18};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h20, 1'b1, 32'h1C};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 32'h00};
    tbl[17] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h20, 1'b0, 32'h00};
    tbl[18] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h24, 1'b0, 32'h00};
    tbl[19] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h28, 1'b1, 32'h20};

    rst             = 1'b1;
    id_ready        = 1'b1;
    imem_req_ready  = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    imem_resp_valid = 1'b0;
    imem_resp_inst  = 32'h0;
    force_junk      = 1'b0;
    lat             = 1;
    last_due        = 0;
    cyc             = 0;
    n_vec           = 0;
    n_err           = 0;
    model_pc        = TB_RESET_PC;
    @(negedge clk);

    // Cycle-exact: streaming, decode back-pressure, cache back-pressure.
    for (int i = 0; i < 20; i++) begin
      rst            = tbl[i].rst;
      id_ready       = tbl[i].idr;
      imem_req_ready = tbl[i].rdy;
      drive_and_settle();
      check($sformatf("tbl%0d_req_valid", i), 32'(imem_req_valid), 32'(tbl[i].erv));
      if (tbl[i].erv) check($sformatf("tbl%0d_req_addr", i), imem_req_addr, tbl[i].eaddr);
      check($sformatf("tbl%0d_if_valid", i), 32'(if_valid), 32'(tbl[i].eiv));
      if (tbl[i].eiv) check($sformatf("tbl%0d_if_pc", i), if_pc, tbl[i].epc);
      finish_cycle();
    end

    // Redirect with two requests outstanding to a misaligned target.
    lat            = 3;
    id_ready       = 1'b1;
    imem_req_ready = 1'b1;
    for (int k = 0; k < 20 && cq.size() != 2; k++) tick();
    check("setup_two_inflight", 32'(cq.size()), 32'd2);
    do_redirect(32'h0000_0103);
    drive_and_settle();
    check("redir_if_valid", 32'(if_valid), 32'd0);
    check("redir_req_addr", imem_req_addr, 32'h0000_0100);
    finish_cycle();
    expect_first_pop("redir_first_pc", 32'h0000_0100);

    // Back-to-back redirects while stale responses are still being dropped.
    do_redirect(32'h0000_0200);
    tick();
    do_redirect(32'h0000_0300);
    expect_first_pop("redir2_first_pc", 32'h0000_0300);

    // Address wrap at the top of the address space.
    lat = 1;
    do_redirect(32'hFFFF_FFFE);
    expect_next_req("wrap_top_addr", 32'hFFFF_FFFC);
    expect_next_req("wrap_next_addr", 32'h0000_0000);
    expect_first_pop("wrap_first_pc", 32'hFFFF_FFFC);

    // Random traffic: back-pressure on both sides, varying latency, sporadic redirects.
    for (int k = 0; k < 300; k++) begin
      id_ready       = ($urandom_range(3, 0) != 0);
      imem_req_ready = ($urandom_range(3, 0) != 0);
      lat            = int'($urandom_range(3, 1));
      if ($urandom_range(31, 0) == 0) do_redirect($urandom);
      else tick();
    end

    // Reset with one request in flight and one instruction buffered.
    lat            = 2;
    id_ready       = 1'b0;
    imem_req_ready = 1'b1;
    do_redirect(32'h0000_0400);
    for (int k = 0; k < 20 && !(cq.size() == 1 && sb.size() == 1); k++) tick();
    check("rst_setup", 32'(cq.size() == 1 && sb.size() == 1), 32'd1);
    rst = 1'b1;
    tick();
    rst        = 1'b0;
    force_junk = 1'b1;
    drive_and_settle();
    check("rst_next_if_valid", 32'(if_valid), 32'd0);
    check("rst_next_req_valid", 32'(imem_req_valid), 32'd1);
    check("rst_next_req_addr", imem_req_addr, TB_RESET_PC);
    finish_cycle();
    force_junk = 1'b0;
    id_ready   = 1'b1;
    lat        = 1;
    expect_first_pop("rst_first_pc", TB_RESET_PC);
    for (int k = 0; k < 10; k++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
